// File: rtl/dual_port_syn_ram.sv
// dual_port_syn_ram: simple dual-port synchronous RAM with one byte-enabled
// write port and one read port. Read latency is RD_LAT (1 or 2) edges and
// every accepted read produces a one-cycle rd_valid strobe.
// After reset a clear sequencer zeroes the whole array; requests are ignored
// until it finishes (init_busy low).
// Optional feature macro: DUAL_PORT_SYN_RAM_BYPASS_EN
//   defined   -> write-first on a same-address read/write collision
//   undefined -> read-first (the read sees the contents from before the write)
module dual_port_syn_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_range, rd_in_range;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] rd_word;

  // Read pipeline: stage 0 is the registered array output, stages 1..RD_LAT
  // carry it to the port. Data only advances with its valid bit so rd_data
  // holds between reads.
  logic [RD_LAT:0]   vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT+1];

  // State and clear-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer: one address zeroed per cycle, leave INIT after the last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      INIT: begin
        clr_we = 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign init_busy   = (state_q == INIT);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_ok       = (state_q == RUN) && wr_en && wr_in_range;
  assign rd_ok       = (state_q == RUN) && rd_en;

  // Array write: clear during INIT, byte-enabled writes during RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[cnt_q] <= '0;
      end else if (wr_ok) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

`ifdef DUAL_PORT_SYN_RAM_BYPASS_EN
  logic wr_hit;
  assign wr_hit = wr_ok && (wr_addr == rd_addr);
`endif

  // Read word selection: out-of-range reads return zero; with bypass a
  // same-address write is merged per byte over the old contents
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
`ifdef DUAL_PORT_SYN_RAM_BYPASS_EN
      if (wr_hit) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
          if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
`endif
    end
  end

  // Read pipeline; reset flushes every stage so in-flight reads are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_ok;
      if (rd_ok) dat_q[0] <= rd_word;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rd_data  = dat_q[RD_LAT];
  assign rd_valid = vld_q[RD_LAT];

endmodule

// File: tb/tb_dual_port_syn_ram.sv
// Bench for dual_port_syn_ram: two instances share one stimulus stream.
//   dut_a: defaults (1024 words, RD_LAT=1)
//   dut_b: 1000 words (out-of-range addresses exist), RD_LAT=2
// Expected read results are pushed into per-instance queues with the cycle
// they are due; independent monitors pop and compare on rd_valid.
module tb_dual_port_syn_ram;

  localparam int DEPTH_B = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [9:0]  wr_addr, rd_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        busy_a, busy_b, rd_valid_a, rd_valid_b;
  logic [31:0] rd_data_a, rd_data_b;

  always #5 clk = ~clk;

  dual_port_syn_ram #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .init_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
  );

  dual_port_syn_ram #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEPTH_B), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .init_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        qa[$], qb[$];
  logic [31:0] model [1024];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Monitor for instance A
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rd_valid_a) begin
      if (qa.size() == 0) begin
        check("unexpected_valid_a", 32'(rd_valid_a), 32'd0);
      end else begin
        e = qa.pop_front();
        check("rd_data_a", rd_data_a, e.data);
        check("rd_due_a", cyc, e.due);
      end
    end else if (qa.size() != 0 && qa[0].due <= cyc) begin
      e = qa.pop_front();
      check("missing_valid_a", 32'(rd_valid_a), 32'd1);
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rd_valid_b) begin
      if (qb.size() == 0) begin
        check("unexpected_valid_b", 32'(rd_valid_b), 32'd0);
      end else begin
        e = qb.pop_front();
        check("rd_data_b", rd_data_b, e.data);
        check("rd_due_b", cyc, e.due);
      end
    end else if (qb.size() != 0 && qb[0].due <= cyc) begin
      e = qb.pop_front();
      check("missing_valid_b", 32'(rd_valid_b), 32'd1);
    end
  end

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  // One RUN-mode cycle of stimulus, issued at a negedge
  task automatic op(input logic wen, input logic [9:0] waddr, input logic [3:0] be,
                    input logic [31:0] wdata, input logic ren, input logic [9:0] raddr);
    logic [31:0] rv;
    wr_en = wen; wr_addr = waddr; wr_be = be; wr_data = wdata;
    rd_en = ren; rd_addr = raddr;
    if (ren) begin
      rv = model[raddr];
`ifdef DUAL_PORT_SYN_RAM_BYPASS_EN
      if (wen && waddr == raddr) rv = merge(model[raddr], wdata, be);
`endif
      qa.push_back('{rv, cyc + 2});
      qb.push_back('{(int'(raddr) >= DEPTH_B) ? 32'd0 : rv, cyc + 3});
    end
    if (wen) model[waddr] = merge(model[waddr], wdata, be);
    @(negedge clk);
    idle();
  endtask

  task automatic reset_checks();
    check("rst_busy_a", 32'(busy_a), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd1);
    check("rst_valid_a", 32'(rd_valid_a), 32'd0);
    check("rst_valid_b", 32'(rd_valid_b), 32'd0);
    check("rst_data_a", rd_data_a, 32'd0);
    check("rst_data_b", rd_data_b, 32'd0);
  endtask

  // Release reset and count cycles with init_busy high; optionally pulse
  // a write and a read during the clear (they must be ignored)
  task automatic release_and_count(input int ignore_at);
    int na, nb;
    na = 0; nb = 0;
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy_a && !busy_b) break;
      if (busy_a) na++;
      if (busy_b) nb++;
      idle();
      if (i == ignore_at) begin
        wr_en = 1'b1; wr_addr = 10'd5; wr_be = 4'hF; wr_data = 32'hFFFF_FFFF;
        rd_en = 1'b1; rd_addr = 10'd5;
      end
      @(negedge clk);
    end
    idle();
    check("init_cycles_a", na, 32'd1024);
    check("init_cycles_b", nb, 32'(DEPTH_B));
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_a", qa.size(), 32'd0);
    check("drain_b", qb.size(), 32'd0);
  endtask

  initial begin
    logic        wen, ren;
    logic [9:0]  wa, ra;
    foreach (model[i]) model[i] = '0;
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    reset_checks();
    release_and_count(10);

    // Cleared contents, including the address hit by the ignored INIT write
    op(0, 0, 0, 0, 1, 10'd0);
    op(0, 0, 0, 0, 1, 10'd511);
    op(0, 0, 0, 0, 1, 10'd1023);
    op(0, 0, 0, 0, 1, 10'd5);
    drain();

    // Byte-enable merge
    op(1, 10'h155, 4'hF, 32'hDEAD_BEEF, 0, 0);
    op(1, 10'h155, 4'b0001, 32'h0000_0011, 0, 0);
    op(0, 0, 0, 0, 1, 10'h155);
    drain();

    // Streaming: 16 writes then 16 back-to-back reads
    for (int a = 0; a < 16; a++) op(1, 10'(a), 4'hF, 32'(a * 3), 0, 0);
    for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, 10'(a));
    drain();

    // Same-address collision, then a follow-up read
    op(1, 10'h20, 4'hF, 32'hAAAA_AAAA, 0, 0);
    op(1, 10'h20, 4'b0011, 32'h1234_5678, 1, 10'h20);
    op(0, 0, 0, 0, 1, 10'h20);
    drain();

    // Random traffic, biased toward a small window for collisions
    for (int n = 0; n < 400; n++) begin
      wen = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 1));
      wa  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? wa : 10'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra = 10'($urandom_range(990, 1023));
      op(wen, wa, 4'($urandom_range(0, 15)), $urandom, ren, ra);
    end
    drain();

    // Reset with two reads in flight: neither may produce rd_valid
    rd_en = 1'b1; rd_addr = 10'h155;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 10'd3; rst = 1'b1;
    @(negedge clk);
    idle();
    reset_checks();
    repeat (3) @(negedge clk);
    check("flush_data_a", rd_data_a, 32'd0);
    check("flush_data_b", rd_data_b, 32'd0);
    foreach (model[i]) model[i] = '0;

    // Reset in the middle of the clear restarts it from address 0
    rst = 1'b0;
    repeat (500) @(negedge clk);
    check("mid_init_busy_a", 32'(busy_a), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    release_and_count(-1);

    // Contents written before the reset are gone
    op(0, 0, 0, 0, 1, 10'h155);
    op(0, 0, 0, 0, 1, 10'h20);
    op(0, 0, 0, 0, 1, 10'd15);
    op(0, 0, 0, 0, 1, 10'd5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_syn_ram.md
# dual_port_syn_ram

Parametrised simple dual-port synchronous RAM, successor to the single-port 1K×32 RAM. It has one write port with byte enables and one independent read port. Read latency is configurable, and every read returns a valid strobe. A built-in clear sequencer zeroes the whole array after reset. It sits in the same local-storage role as the single-port RAM, for blocks that need a concurrent read and write every cycle.

## Interface
Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 10, address width.
- DEPTH, 1<<ADDR_W, number of words; legal range 2..2^ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- init_busy  out  1  high while the array is being cleared.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  DATA_W/8  byte enables; bit i covers data bits [8i+7:8i].
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; holds its value until the next valid read.
- rd_valid  out  1  one-cycle strobe marking rd_data as new.

## Operation
- States are INIT and RUN.
- Reset:
  - While rst is high: state=INIT, clear counter=0, init_busy=1, rd_valid=0, rd_data=0, and the read pipeline is flushed.
  - rst asserted in any state (including mid-INIT or with reads in flight) restarts the clear from address 0. No rd_valid is produced for reads issued before rst.
- INIT:
  - Each cycle with rst low, writes 0 to address = counter, then increments the counter.
  - On the edge that clears DEPTH-1: state goes to RUN and init_busy goes to 0.
  - wr_en and rd_en are ignored in INIT. Writes are dropped; reads produce no rd_valid.
- RUN writes:
  - On an edge with wr_en=1, each byte whose wr_be bit is set is written; other bytes keep their value.
  - wr_be=0 is a no-op.
- RUN reads:
  - On an edge with rd_en=1, the read of rd_addr is issued. rd_data and rd_valid appear RD_LAT edges later.
  - Back-to-back reads are allowed every cycle; throughput is 1 per cycle.
- Out-of-range addresses (addr >= DEPTH, only possible when DEPTH < 2^ADDR_W):
  - Writes are ignored.
  - Reads return 0 with rd_valid=1.
- Simultaneous write and read at different addresses: fully independent.
- Simultaneous write and read at the same address: result is set by the macro (see Configuration).

## Timing
- Clear duration: exactly DEPTH cycles after rst falls. With defaults, init_busy deasserts 1024 edges after the first edge with rst=0.
- First accepted operation: the first edge at which init_busy is already 0.
- RD_LAT=1: rd_en sampled at edge N gives rd_data/rd_valid valid after edge N+1... (registered array output).
- RD_LAT=2: an extra output register adds one cycle. Both rd_data and rd_valid shift together.
- Write latency: data written at edge N is visible to a read issued at edge N+1 in all configurations.
- rd_valid is high for exactly one cycle per accepted read. rd_data is not cleared between reads.

## Configuration
- Macro: DUAL_PORT_SYN_RAM_BYPASS_EN.
- Defined (write-first): a read issued on the same edge as a write to the same address returns the new data, merged per byte. Enabled bytes come from wr_data; disabled bytes come from the old array contents.
- Undefined (read-first): the read returns the array contents from before that write. The write still takes effect for later reads.
- The latency and rd_valid timing are identical in both modes.

## Test plan
- Reset/clear: hold rst=1 for 3 cycles, then release.
  - init_busy=1 for exactly 1024 cycles, then 0.
  - Read addresses 0, 511 and 1023: rd_data=0x00000000 with rd_valid=1 after RD_LAT cycles.
- Byte-enable write: write 0xDEADBEEF to address 0x155 with be=4'hF, then 0x00000011 with be=4'b0001.
  - A read of 0x155 returns 0xDEADBE11.
- Streaming: write addresses 0–15 with data=addr*3, then issue reads of 0–15 on 16 consecutive cycles.
  - rd_valid is high 16 consecutive cycles, data in order.
  - Repeat with RD_LAT=2: each result is one cycle later.
- Collision: address 0x20 holds 0xAAAAAAAA. On the same edge, write 0x12345678 with be=4'b0011 and read 0x20.
  - With the macro: returns 0xAAAA5678.
  - Without the macro: returns 0xAAAAAAAA.
  - A subsequent read returns 0xAAAA5678 in both modes.
- Reset mid-operation:
  - Assert rst during INIT at counter=500: init_busy stays 1 for a full 1024 cycles after release.
  - Assert rst with 2 reads in flight: no rd_valid follows, and rd_data=0.
- Ignored ops in INIT: pulse wr_en (addr 5, data 0xFFFFFFFF) and rd_en during INIT.
  - No rd_valid is produced.
  - A later read of address 5 returns 0.
